rr_sel_arbiter_4: RTL and testbench

Round-robin arbiter that drives the select of the 4-to-1, 4-bit channel mux from four requesting sources (a, b, c, d ↔ req[0..3]). It sits directly upstream of the mux. It grants one source at a time and holds each grant for a bounded dwell. It presents a registered sel/grant so the mux output is glitch-free and stable per clk edge.

---
 rtl/rr_sel_arbiter_4_if.sv | 30 +++
 rtl/rr_sel_arbiter_4.sv | 120 ++++++++++++
 tb/tb_rr_sel_arbiter_4.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rr_sel_arbiter_4_if.sv
// Request/grant bundle between four requesting sources and the round-robin
// arbiter that steers the 4-to-1 channel mux select.
interface rr_sel_arbiter_4_if #(
    parameter int CNT_W = 4
);
    logic [3:0]       req;
    logic             done;
    logic [1:0]       sel;
    logic [3:0]       grant;
    logic             valid;
    logic [CNT_W-1:0] dwell_cnt;

    modport master (
        output req,
        output done,
        input  sel,
        input  grant,
        input  valid,
        input  dwell_cnt
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output grant,
        output valid,
        output dwell_cnt
    );
endinterface

// File: rtl/rr_sel_arbiter_4.sv
// Round-robin arbiter driving the select of a 4-to-1 mux. Each grant is held
// for at most DWELL cycles, and every output is registered.
module rr_sel_arbiter_4 #(
    parameter int DWELL = 4,
    parameter int CNT_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    rr_sel_arbiter_4_if.slave bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [1:0]       last_q, last_d;

    logic             win_found;
    logic [1:0]       win_idx;
    logic             grant_end;

    // Search starts just after the previous winner. The fourth candidate is
    // the previous winner itself, so it re-wins only when no other source asks.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!win_found && bus.req[last_q + 2'(i + 1)]) begin
                win_found = 1'b1;
                win_idx   = last_q + 2'(i + 1);
            end
        end
    end

    assign grant_end = bus.done | ~bus.req[sel_q] | (dwell_q == DWELL_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        dwell_d = dwell_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    sel_d   = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    valid_d = 1'b1;
                    dwell_d = '0;
                    last_d  = win_idx;
                end else begin
                    grant_d = 4'b0000;
                    valid_d = 1'b0;
                    dwell_d = '0;
                end
            end
            BUSY: begin
                if (grant_end) begin
                    // Hand over in the same cycle so valid shows no bubble.
                    if (win_found) begin
                        sel_d   = win_idx;
                        grant_d = 4'b0001 << win_idx;
                        valid_d = 1'b1;
                        dwell_d = '0;
                        last_d  = win_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                        valid_d = 1'b0;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                valid_d = 1'b0;
                dwell_d = '0;
            end
        endcase
    end

    // A reset pointer of 3 makes the very first search begin at source 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            dwell_q <= '0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            dwell_q <= dwell_d;
            last_q  <= last_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.grant     = grant_q;
    assign bus.valid     = valid_q;
    assign bus.dwell_cnt = dwell_q;

endmodule

// File: tb/tb_rr_sel_arbiter_4.sv
// Scoreboard bench: two arbiters (DWELL=4 and DWELL=1) are driven with
// directed vectors whose registered responses are checked one cycle later.
module tb_rr_sel_arbiter_4;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic [3:0] dwell;
    } exp_t;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    rr_sel_arbiter_4_if #(.CNT_W(4)) if_a ();
    rr_sel_arbiter_4_if #(.CNT_W(4)) if_b ();

    rr_sel_arbiter_4 #(.DWELL(4), .CNT_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    rr_sel_arbiter_4 #(.DWELL(1), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got sel=%0d grant=%b valid=%b dwell=%0d, expected sel=%0d grant=%b valid=%b dwell=%0d",
                     tag, $time, act.sel, act.grant, act.valid, act.dwell,
                     exp.sel, exp.grant, exp.valid, exp.dwell);
        end
    endtask

    function automatic exp_t actA();
        return '{sel: if_a.sel, grant: if_a.grant, valid: if_a.valid, dwell: if_a.dwell_cnt};
    endfunction

    function automatic exp_t actB();
        return '{sel: if_b.sel, grant: if_b.grant, valid: if_b.valid, dwell: if_b.dwell_cnt};
    endfunction

    // Called at a negedge: drive one cycle of inputs and queue the state the
    // DUT must show after the coming posedge.
    task automatic applyStimulus(input bit use_b, input logic [3:0] req, input logic done,
                                 input logic [1:0] e_sel, input logic [3:0] e_grant,
                                 input logic [3:0] e_dwell);
        exp_t e;
        e.sel   = e_sel;
        e.grant = e_grant;
        e.valid = (e_grant != 4'b0000);
        e.dwell = e_dwell;
        if (use_b) begin
            if_b.req  = req;
            if_b.done = done;
            q_b.push_back(e);
        end else begin
            if_a.req  = req;
            if_a.done = done;
            q_a.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) checkOutput("dwell4", actA(), q_a.pop_front());
        if (q_b.size() > 0) checkOutput("dwell1", actB(), q_b.pop_front());
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t rst_exp;
        rst_exp = '{sel: 2'd0, grant: 4'b0000, valid: 1'b0, dwell: 4'd0};

        rst_n     = 1'b0;
        if_a.req  = 4'b0000;
        if_a.done = 1'b0;
        if_b.req  = 4'b0000;
        if_b.done = 1'b0;
        #2;
        checkOutput("reset_a", actA(), rst_exp);
        checkOutput("reset_b", actB(), rst_exp);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] test 1: single requester, dwell expiry and re-grant");
        applyStimulus(0, 4'b0001, 1'b0, 2'd0, 4'b0001, 4'd0);
        applyStimulus(0, 4'b0001, 1'b0, 2'd0, 4'b0001, 4'd1);
        applyStimulus(0, 4'b0001, 1'b0, 2'd0, 4'b0001, 4'd2);
        applyStimulus(0, 4'b0001, 1'b0, 2'd0, 4'b0001, 4'd3);
        applyStimulus(0, 4'b0001, 1'b0, 2'd0, 4'b0001, 4'd0);
        applyStimulus(0, 4'b0001, 1'b0, 2'd0, 4'b0001, 4'd1);

        $display("[TB] test 2: all four requesting");
        doReset();
        for (int k = 0; k < 17; k++) begin
            logic [1:0] s;
            s = 2'((k / 4) % 4);
            applyStimulus(0, 4'b1111, 1'b0, s, 4'b0001 << s, 4'(k % 4));
        end

        $display("[TB] test 3: early release with done");
        doReset();
        applyStimulus(0, 4'b0101, 1'b0, 2'd0, 4'b0001, 4'd0);
        applyStimulus(0, 4'b0101, 1'b0, 2'd0, 4'b0001, 4'd1);
        applyStimulus(0, 4'b0101, 1'b1, 2'd2, 4'b0100, 4'd0);
        applyStimulus(0, 4'b0101, 1'b0, 2'd2, 4'b0100, 4'd1);
        applyStimulus(0, 4'b0101, 1'b1, 2'd0, 4'b0001, 4'd0);

        $display("[TB] test 4: requests drop to idle, select held");
        doReset();
        applyStimulus(0, 4'b0100, 1'b0, 2'd2, 4'b0100, 4'd0);
        applyStimulus(0, 4'b0100, 1'b0, 2'd2, 4'b0100, 4'd1);
        applyStimulus(0, 4'b0000, 1'b0, 2'd2, 4'b0000, 4'd0);
        applyStimulus(0, 4'b1000, 1'b0, 2'd3, 4'b1000, 4'd0);
        applyStimulus(0, 4'b1000, 1'b0, 2'd3, 4'b1000, 4'd1);
        applyStimulus(0, 4'b1000, 1'b0, 2'd3, 4'b1000, 4'd2);

        $display("[TB] test 5: asynchronous reset mid-grant");
        rst_n    = 1'b0;
        if_a.req = 4'b1001;
        #1;
        checkOutput("async_reset", actA(), rst_exp);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 4'b1001, 1'b0, 2'd0, 4'b0001, 4'd0);
        applyStimulus(0, 4'b1001, 1'b0, 2'd0, 4'b0001, 4'd1);

        $display("[TB] test 6: DWELL=1 rotation");
        if_a.req = 4'b0000;
        doReset();
        applyStimulus(1, 4'b0110, 1'b0, 2'd1, 4'b0010, 4'd0);
        applyStimulus(1, 4'b0110, 1'b0, 2'd2, 4'b0100, 4'd0);
        applyStimulus(1, 4'b0110, 1'b0, 2'd1, 4'b0010, 4'd0);
        applyStimulus(1, 4'b0110, 1'b0, 2'd2, 4'b0100, 4'd0);

        @(negedge clk);
        checks++;
        if (q_a.size() + q_b.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", q_a.size() + q_b.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
